lv_value_predictor: RTL and testbench



---
 rtl/lv_value_predictor_if.sv | 39 +++
 rtl/lv_value_predictor.sv | 158 +++++++++++++++
 tb/tb_lv_value_predictor.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/lv_value_predictor_if.sv
// lv_value_predictor_if: request / prediction / resolve bundle between the MEM
// stage (master) and the last-value load predictor (slave).
//   req_valid, req_pc        : load lookup request           (master -> slave)
//   req_ready                : pending FIFO has room         (slave -> master)
//   pred_valid, pred_value   : registered prediction         (slave -> master)
//   res_valid, res_data      : D-cache data for oldest load  (master -> slave)
//   done, recover, recover_pc: verification result pulses    (slave -> master)
//   flush                    : squash all pending loads      (master -> slave)
//   pend_count               : FIFO occupancy                (slave -> master)
interface lv_value_predictor_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PEND_DEPTH = 4
);
    localparam int CW = $clog2(PEND_DEPTH) + 1;

    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  req_ready;
    logic                  pred_valid;
    logic [DATA_WIDTH-1:0] pred_value;
    logic                  res_valid;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  done;
    logic                  recover;
    logic [ADDR_WIDTH-1:0] recover_pc;
    logic                  flush;
    logic [CW-1:0]         pend_count;

    modport master (
        output req_valid, req_pc, res_valid, res_data, flush,
        input  req_ready, pred_valid, pred_value, done, recover, recover_pc, pend_count
    );

    modport slave (
        input  req_valid, req_pc, res_valid, res_data, flush,
        output req_ready, pred_valid, pred_value, done, recover, recover_pc, pend_count
    );
endinterface

// File: rtl/lv_value_predictor.sv
// lv_value_predictor: PC-indexed, tagged last-value load predictor with
// saturating confidence and an in-order FIFO of outstanding loads.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : lv_value_predictor_if.slave (request, prediction, resolve, verify)
//   stat_pred/stat_correct/stat_wrong : saturating event counters, present only
//              when the VP_STATS_EN macro is defined
module lv_value_predictor #(
    parameter int INDEX_WIDTH = 6,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int CONF_BITS   = 2,
    parameter int CONF_THRESH = 2,
    parameter int PEND_DEPTH  = 4
) (
    input logic clk,
    input logic rst,
    lv_value_predictor_if.slave bus
`ifdef VP_STATS_EN
    ,
    output logic [31:0] stat_pred,
    output logic [31:0] stat_correct,
    output logic [31:0] stat_wrong
`endif
);
    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int TAG_W   = ADDR_WIDTH - INDEX_WIDTH - 2;
    localparam int PW      = $clog2(PEND_DEPTH);
    localparam int CW      = PW + 1;
    localparam logic [CONF_BITS-1:0] CONF_MAX = '1;

    logic                  tbl_valid [ENTRIES];
    logic [TAG_W-1:0]      tbl_tag   [ENTRIES];
    logic [DATA_WIDTH-1:0] tbl_val   [ENTRIES];
    logic [CONF_BITS-1:0]  tbl_conf  [ENTRIES];

    logic [ADDR_WIDTH-1:0] fifo_pc   [PEND_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_val  [PEND_DEPTH];
    logic                  fifo_pred [PEND_DEPTH];
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         count;

    logic                  pred_valid_q, done_q, recover_q;
    logic [DATA_WIDTH-1:0] pred_value_q;
    logic [ADDR_WIDTH-1:0] recover_pc_q;

    logic [ADDR_WIDTH-1:0] head_pc;
    logic                  pop, accept, ready, vfy, match, mispred, confident;
    logic [INDEX_WIDTH-1:0] tr_idx, rq_idx;
    logic [TAG_W-1:0]      tr_tag, rq_tag, lk_tag;
    logic                  tr_hit, lk_valid, bypass;
    logic [DATA_WIDTH-1:0] lk_val;
    logic [CONF_BITS-1:0]  tr_conf, lk_conf;
    logic                  unused_ok;

    always_comb begin
        head_pc = fifo_pc[head];
        ready   = count < CW'(PEND_DEPTH);   // pre-pop count: full blocks even while popping
        pop     = bus.res_valid && (count != '0);
        accept  = bus.req_valid && ready && !bus.flush && !recover_q;

        // training of the entry owned by the head load
        tr_idx  = head_pc[INDEX_WIDTH+1:2];
        tr_tag  = head_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
        tr_hit  = tbl_valid[tr_idx] && (tbl_tag[tr_idx] == tr_tag);
        tr_conf = '0;
        if (tr_hit && (tbl_val[tr_idx] == bus.res_data))
            tr_conf = (tbl_conf[tr_idx] == CONF_MAX) ? CONF_MAX : tbl_conf[tr_idx] + 1'b1;

        // verification is suppressed by a same-cycle flush
        match   = fifo_val[head] == bus.res_data;
        vfy     = pop && !bus.flush && fifo_pred[head];
        mispred = vfy && !match;

        // lookup sees this cycle's training write (write-first)
        rq_idx   = bus.req_pc[INDEX_WIDTH+1:2];
        rq_tag   = bus.req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
        bypass   = pop && (tr_idx == rq_idx);
        lk_valid = bypass ? 1'b1         : tbl_valid[rq_idx];
        lk_tag   = bypass ? tr_tag       : tbl_tag[rq_idx];
        lk_val   = bypass ? bus.res_data : tbl_val[rq_idx];
        lk_conf  = bypass ? tr_conf      : tbl_conf[rq_idx];
        confident = lk_valid && (lk_tag == rq_tag) && (lk_conf >= CONF_BITS'(CONF_THRESH));
    end

    assign unused_ok      = ^{bus.req_pc[1:0], head_pc[1:0]};
    assign bus.req_ready  = ready;
    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_value = pred_value_q;
    assign bus.done       = done_q;
    assign bus.recover    = recover_q;
    assign bus.recover_pc = recover_pc_q;
    assign bus.pend_count = count;

    // FIFO payload needs no reset: occupancy is tracked by count alone
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_pc[tail]   <= bus.req_pc;
            fifo_val[tail]  <= lk_val;
            fifo_pred[tail] <= confident;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_tag[i]   <= '0;
                tbl_val[i]   <= '0;
                tbl_conf[i]  <= '0;
            end
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            pred_valid_q <= 1'b0;
            pred_value_q <= '0;
            done_q       <= 1'b0;
            recover_q    <= 1'b0;
            recover_pc_q <= '0;
        end else begin
            if (pop) begin
                tbl_valid[tr_idx] <= 1'b1;
                tbl_tag[tr_idx]   <= tr_tag;
                tbl_val[tr_idx]   <= bus.res_data;
                tbl_conf[tr_idx]  <= tr_conf;
            end
            pred_valid_q <= accept && confident;
            pred_value_q <= (accept && confident) ? lk_val : '0;
            done_q       <= vfy && match;
            recover_q    <= mispred;
            recover_pc_q <= mispred ? head_pc : '0;
            // a mispredict discards every younger load, including one pushed now
            if (bus.flush || mispred) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PW'(pop);
                tail  <= tail + PW'(accept);
                count <= count + CW'(accept) - CW'(pop);
            end
        end
    end

`ifdef VP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pred    <= '0;
            stat_correct <= '0;
            stat_wrong   <= '0;
        end else begin
            if (pred_valid_q && stat_pred    != '1) stat_pred    <= stat_pred + 1'b1;
            if (done_q       && stat_correct != '1) stat_correct <= stat_correct + 1'b1;
            if (recover_q    && stat_wrong   != '1) stat_wrong   <= stat_wrong + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_lv_value_predictor.sv
module tb_lv_value_predictor;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lv_value_predictor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PEND_DEPTH(DEPTH)) bus ();

`ifdef VP_STATS_EN
    logic [31:0] stat_pred, stat_correct, stat_wrong;
`endif

    lv_value_predictor #(
        .INDEX_WIDTH(6), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .CONF_BITS(2), .CONF_THRESH(2), .PEND_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef VP_STATS_EN
        ,
        .stat_pred(stat_pred),
        .stat_correct(stat_correct),
        .stat_wrong(stat_wrong)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: table of last values plus a queue of outstanding loads
    typedef struct {
        logic [31:0] pc;
        logic [31:0] val;
        bit          pred;
    } pend_t;
    pend_t       mq[$];
    bit          m_v    [64];
    logic [23:0] m_tag  [64];
    logic [31:0] m_val  [64];
    int          m_conf [64];
    bit          m_rec;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 0; m_tag[i] = '0; m_val[i] = '0; m_conf[i] = 0;
        end
        m_rec = 0;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] data);
        int i;
        i = idx_of(pc);
        if (m_v[i] && m_tag[i] == pc[31:8] && m_val[i] == data)
            m_conf[i] = (m_conf[i] >= 3) ? 3 : m_conf[i] + 1;
        else
            m_conf[i] = 0;
        m_v[i]   = 1;
        m_tag[i] = pc[31:8];
        m_val[i] = data;
    endtask

    // one clock: check ready, drive inputs, predict outputs, check after the edge
    task automatic step(input bit rv, input logic [31:0] pc, input bit resv,
                        input logic [31:0] rd, input bit fl);
        bit acc, conf, e_done, e_rec, e_pv;
        logic [31:0] e_rpc, e_pval;
        pend_t h;
        int i;
        chk("req_ready", bus.req_ready, (mq.size() < DEPTH));
        bus.req_valid = rv; bus.req_pc = pc;
        bus.res_valid = resv; bus.res_data = rd; bus.flush = fl;

        acc = rv && (mq.size() < DEPTH) && !fl && !m_rec;
        e_done = 0; e_rec = 0; e_rpc = '0;
        if (resv && mq.size() > 0) begin
            h = mq.pop_front();
            train(h.pc, rd);
            if (!fl && h.pred) begin
                if (rd == h.val) e_done = 1;
                else begin e_rec = 1; e_rpc = h.pc; end
            end
        end
        i = idx_of(pc);
        conf   = m_v[i] && m_tag[i] == pc[31:8] && m_conf[i] >= 2;
        e_pv   = acc && conf;
        e_pval = e_pv ? m_val[i] : '0;
        if (acc) mq.push_back('{pc: pc, val: m_val[i], pred: conf});
        if (fl || e_rec) mq.delete();
        m_rec = e_rec;

        @(posedge clk); #1;
        chk("pred_valid", bus.pred_valid, e_pv);
        chk("pred_value", bus.pred_value, e_pval);
        chk("done", bus.done, e_done);
        chk("recover", bus.recover, e_rec);
        if (e_rec) chk("recover_pc", bus.recover_pc, e_rpc);
        chk("pend_count", bus.pend_count, mq.size());
        chk("excl", bus.done & bus.recover, 0);
    endtask

    task automatic idle();
        step(0, '0, 0, '0, 0);
    endtask

    logic [31:0] rpcs [5] = '{32'h40, 32'h44, 32'h140, 32'h80, 32'h1040};
    logic [31:0] rval [5];

    initial begin
        rst = 1'b1;
        bus.req_valid = 0; bus.req_pc = '0; bus.res_valid = 0; bus.res_data = '0; bus.flush = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_pred_valid", bus.pred_valid, 0);
        chk("rst_pred_value", bus.pred_value, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_recover", bus.recover, 0);
        chk("rst_recover_pc", bus.recover_pc, 0);
        chk("rst_pend_count", bus.pend_count, 0);

        // cold miss then allocate
        step(1, 32'h40, 0, '0, 0);
        chk("cold_pred", bus.pred_valid, 0);
        step(0, '0, 1, 32'h1234, 0);
        chk("cold_nodone", bus.done | bus.recover, 0);
        repeat (2) begin
            step(1, 32'h40, 0, '0, 0);
            step(0, '0, 1, 32'h1234, 0);
        end
        step(1, 32'h40, 0, '0, 0);
        chk("conf_pred_valid", bus.pred_valid, 1);
        chk("conf_pred_value", bus.pred_value, 32'h1234);
        step(0, '0, 1, 32'h1234, 0);
        chk("conf_done", bus.done, 1);

        // confident mispredict squashes the younger load
        step(1, 32'h40, 0, '0, 0);
        step(1, 32'h44, 0, '0, 0);
        chk("two_pending", bus.pend_count, 2);
        step(0, '0, 1, 32'h9999, 0);
        chk("mis_recover", bus.recover, 1);
        chk("mis_recover_pc", bus.recover_pc, 32'h40);
        chk("mis_empty", bus.pend_count, 0);
        step(1, 32'h80, 0, '0, 0);   // ignored during the recover cycle

        // fill, then full blocks a push even while popping
        for (int k = 0; k < 4; k++) step(1, 32'h80 + 32'(4 * k), 0, '0, 0);
        chk("full_ready", bus.req_ready, 0);
        step(1, 32'h90, 1, 32'h55, 0);
        chk("full_pop", bus.pend_count, 3);

        // flush, then resolve on empty FIFO
        step(0, '0, 0, '0, 1);
        chk("flush_empty", bus.pend_count, 0);
        step(0, '0, 1, 32'h5, 0);
        chk("empty_res", bus.pend_count, 0);

        // aliasing: 0x140 retags the 0x40 entry
        repeat (3) begin
            step(1, 32'h40, 0, '0, 0);
            step(0, '0, 1, 32'h9999, 0);
        end
        step(1, 32'h140, 0, '0, 0);
        step(0, '0, 1, 32'h777, 0);
        step(1, 32'h40, 0, '0, 0);
        chk("alias_pred", bus.pred_valid, 0);
        step(0, '0, 1, 32'h9999, 0);

        // randomized traffic over a few aliasing PCs with mostly stable values
        for (int k = 0; k < 5; k++) rval[k] = $urandom;
        for (int n = 0; n < 1500; n++) begin
            bit rv, resv, fl;
            int s;
            logic [31:0] pc, rd;
            rv   = ($urandom_range(99) < 55);
            resv = ($urandom_range(99) < 45);
            fl   = ($urandom_range(99) < 3);
            pc   = rpcs[$urandom_range(4)];
            rd   = $urandom;
            if (mq.size() > 0) begin
                for (int k = 0; k < 5; k++) if (rpcs[k] == mq[0].pc) s = k;
                if ($urandom_range(99) < 85) rd = rval[s];
                else rval[s] = rd;
            end
            step(rv, pc, resv, rd, fl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
